// File: rtl/cpu_defs.sv
// ============================================================================
// Package : cpu_defs
// Purpose : Definitions shared by the fetch unit and the fetch queue: the
//           PC value after reset, the NOP encoding, and the fetched-entry type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // One fetched instruction together with its address. Packed so that the
    // PC occupies bits [63:32] and the instruction occupies bits [31:0].
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage : cpu_defs

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module  : fetch_queue
// Purpose : In-order decoupling buffer between instruction fetch and decode.
//           It stores {pc, instr} pairs, holds off fetch when full, and a
//           flush discards everything it holds (branch/jump redirect).
// Ports   : clk, reset (async, active-low)
//           in_valid/in_pc/in_instr/in_ready   - push side (fetch)
//           out_valid/out_pc/out_instr/out_ready - pop side (decode)
//           flush                                - drop all entries
//           count                                - occupancy, 0..DEPTH
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter logic [31:0] NOP      = cpu_defs::NOP
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    import cpu_defs::fetch_entry_t;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occ;
    logic             push;
    logic             pop;
    fetch_entry_t     head;

    // Both handshake readies come from the registered occupancy only, so
    // there is no combinational path from out_ready to in_ready.
    assign in_ready  = (occ != FULL_CNT);
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = occ;

    // No bypass: an empty queue shows the reset PC / NOP, never in_*.
    assign head      = mem[rd_ptr];
    assign out_pc    = out_valid ? head.pc    : RESET_PC;
    assign out_instr = out_valid ? head.instr : NOP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            // Redirect wins over any push/pop offered in the same cycle.
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                occ <= occ + CNT_ONE;
            end else if (pop && !push) begin
                occ <= occ - CNT_ONE;
            end
        end
    end

    // Storage is not reset; entries are only observable while counted.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
        end
    end

endmodule : fetch_queue

`default_nettype wire
